alu_seq_ctrl: RTL and testbench

Single-button sequencer for the board-level ALU datapath. It debounces the operator's button and steps an FSM that captures operand A, operand B and the opcode from the switches in turn. It then holds them on the ALU inputs, registers the combinational ALU result one cycle later and presents it until the next press. It sits between the Basys3 switches/buttons and the ALU, replacing three-button input capture with a guided one-button flow plus a clear button.

---
 rtl/alu_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// One-button operand/opcode sequencer for the board ALU: debounced "next" and
// "clear" buttons step A -> B -> Op -> execute -> show, with results registered.

module alu_seq_db #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic button,
  output logic pulse
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      deb    <= 1'b0;
      deb_d  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= button;
      sync_2 <= sync_1;
      deb_d  <= deb;
      // Any cycle where the levels agree restarts the qualification window.
      if (sync_2 != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= sync_2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = deb & ~deb_d;
endmodule

module alu_seq_ctrl #(
  parameter int N_SW       = 14,
  parameter int N_OP       = 6,
  parameter int N_OPERANDS = 4,
  parameter int DB_CYCLES  = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [N_SW-1:0]       i_sw,
  input  logic                  i_button,
  input  logic                  i_button_clr,
  input  logic [N_OPERANDS-1:0] i_alu_result,
  output logic [N_OPERANDS-1:0] o_alu_A,
  output logic [N_OPERANDS-1:0] o_alu_B,
  output logic [N_OP-1:0]       o_alu_Op,
  output logic [N_OPERANDS-1:0] o_result,
  output logic                  o_result_valid,
  output logic [2:0]            o_state
);
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic next_pulse;
  logic clr_pulse;
  logic ld_a;
  logic ld_b;
  logic ld_op;
  logic cap_result;
  logic clr_valid;

  alu_seq_db #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .button  (i_button),
    .pulse   (next_pulse)
  );

  alu_seq_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .button  (i_button_clr),
    .pulse   (clr_pulse)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_A;
    else         state <= state_next;
  end

  // Clear overrides everything, including a simultaneous next press.
  always_comb begin
    state_next = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_op      = 1'b0;
    cap_result = 1'b0;
    clr_valid  = 1'b0;
    if (clr_pulse) begin
      state_next = S_A;
      clr_valid  = 1'b1;
    end else begin
      case (state)
        S_A: if (next_pulse) begin
          ld_a       = 1'b1;
          state_next = S_B;
        end
        S_B: if (next_pulse) begin
          ld_b       = 1'b1;
          state_next = S_OP;
        end
        S_OP: if (next_pulse) begin
          ld_op      = 1'b1;
          state_next = S_EXEC;
        end
        S_EXEC: begin
          cap_result = 1'b1;
          state_next = S_SHOW;
        end
        S_SHOW: if (next_pulse) begin
          clr_valid  = 1'b1;
          state_next = S_A;
        end
        default: begin
          clr_valid  = 1'b1;
          state_next = S_A;
        end
      endcase
    end
  end

  // o_result_valid is high only in S_SHOW, where o_result matches the held operands.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_alu_A        <= '0;
      o_alu_B        <= '0;
      o_alu_Op       <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
    end else begin
      if (ld_a)  o_alu_A  <= i_sw[N_OPERANDS-1:0];
      if (ld_b)  o_alu_B  <= i_sw[2*N_OPERANDS-1:N_OPERANDS];
      if (ld_op) o_alu_Op <= i_sw[N_SW-1:N_SW-N_OP];
      if (cap_result) begin
        o_result       <= i_alu_result;
        o_result_valid <= 1'b1;
      end else if (clr_valid) begin
        o_result_valid <= 1'b0;
      end
    end
  end

  assign o_state = state;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a short debounce window and an A+B mod 16 ALU stub;
// expected outputs come from a press-level model of the operator flow.

module tb_alu_seq_ctrl;
  localparam int N_SW       = 14;
  localparam int N_OP       = 6;
  localparam int N_OPERANDS = 4;
  localparam int DB_CYCLES  = 4;
  localparam int PRESS_LAT  = 2 + DB_CYCLES + 1;

  logic                  i_clock;
  logic                  i_reset;
  logic [N_SW-1:0]       i_sw;
  logic                  i_button;
  logic                  i_button_clr;
  logic [N_OPERANDS-1:0] i_alu_result;
  logic [N_OPERANDS-1:0] o_alu_A;
  logic [N_OPERANDS-1:0] o_alu_B;
  logic [N_OP-1:0]       o_alu_Op;
  logic [N_OPERANDS-1:0] o_result;
  logic                  o_result_valid;
  logic [2:0]            o_state;

  int checks = 0;
  int errors = 0;

  // Operator-flow model: step 0..4 = waiting for A, B, Op, executing, showing.
  int                    m_step;
  logic [N_OPERANDS-1:0] m_a;
  logic [N_OPERANDS-1:0] m_b;
  logic [N_OP-1:0]       m_op;
  logic [N_OPERANDS-1:0] m_res;
  logic                  m_valid;
  logic [N_OPERANDS-1:0] exp_q[$];

  alu_seq_ctrl #(
    .N_SW       (N_SW),
    .N_OP       (N_OP),
    .N_OPERANDS (N_OPERANDS),
    .DB_CYCLES  (DB_CYCLES)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_sw           (i_sw),
    .i_button       (i_button),
    .i_button_clr   (i_button_clr),
    .i_alu_result   (i_alu_result),
    .o_alu_A        (o_alu_A),
    .o_alu_B        (o_alu_B),
    .o_alu_Op       (o_alu_Op),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_state        (o_state)
  );

  // Clock and the external ALU stub.
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;
  assign i_alu_result = o_alu_A + o_alu_B;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_step = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_next(input logic [N_SW-1:0] sw);
    case (m_step)
      0: begin m_a = sw[3:0]; m_step = 1; end
      1: begin m_b = sw[7:4]; m_step = 2; end
      2: begin
        m_op = sw[13:8];
        exp_q.push_back(4'((int'(m_a) + int'(m_b)) % 16));
        m_step = 3;
      end
      4: begin m_valid = 1'b0; m_step = 0; end
      default: ;
    endcase
  endtask

  task automatic m_exec();
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL exec_queue observed=empty expected=entry");
    end else begin
      m_res = exp_q.pop_front();
    end
    m_valid = 1'b1;
    m_step  = 4;
  endtask

  task automatic m_clear();
    m_step  = 0;
    m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_state"}, o_state, m_step);
    check({tag, "_A"}, o_alu_A, m_a);
    check({tag, "_B"}, o_alu_B, m_b);
    check({tag, "_Op"}, o_alu_Op, m_op);
    check({tag, "_result"}, o_result, m_res);
    check({tag, "_valid"}, o_result_valid, m_valid);
  endtask

  // Holds the selected raw buttons; the requested switch value is present only
  // in the pulse cycle, random switches elsewhere.
  task automatic press(input bit nxt, input bit clr, input logic [N_SW-1:0] sw_val);
    i_button     = nxt;
    i_button_clr = clr;
    repeat (PRESS_LAT - 1) begin
      i_sw = N_SW'($urandom);
      tick();
    end
    check("pre_pulse_state", o_state, m_step);
    i_sw = sw_val;
    tick();
    i_button     = 1'b0;
    i_button_clr = 1'b0;
    i_sw         = N_SW'($urandom);
    if (clr) m_clear();
    else     m_next(sw_val);
    check_all("press");
    if (m_step == 3) begin
      tick();
      m_exec();
      check_all("exec");
    end
    repeat (8) begin
      i_sw = N_SW'($urandom);
      tick();
    end
    check_all("idle");
  endtask

  initial begin
    logic [N_SW-1:0] v;
    int n;

    // Reset with busy inputs.
    i_reset      = 1'b1;
    i_button     = 1'($urandom);
    i_button_clr = 1'($urandom);
    i_sw         = N_SW'($urandom);
    tick(2);
    i_reset      = 1'b0;
    i_button     = 1'b0;
    i_button_clr = 1'b0;
    m_reset();
    check_all("reset");

    // Directed A=3, B=5, Op=0x20 flow.
    v = N_SW'($urandom); v[3:0] = 4'h3;
    press(1, 0, v);
    check("seq_A", o_alu_A, 32'h3);
    v = N_SW'($urandom); v[7:4] = 4'h5;
    press(1, 0, v);
    check("seq_B", o_alu_B, 32'h5);
    v = N_SW'($urandom); v[13:8] = 6'b100000;
    press(1, 0, v);
    check("seq_Op", o_alu_Op, 32'h20);
    check("seq_result", o_result, 32'h8);
    check("seq_valid", o_result_valid, 32'h1);
    check("seq_show", o_state, 32'h4);
    press(1, 0, N_SW'($urandom));
    check("ret_state", o_state, 32'h0);
    check("ret_valid", o_result_valid, 32'h0);
    check("ret_result", o_result, 32'h8);

    // Bounce: short high runs must not qualify, then a clean press.
    v = N_SW'($urandom);
    i_sw = v;
    repeat ($urandom_range(3, 6)) begin
      i_button = 1'b1;
      tick($urandom_range(1, DB_CYCLES - 1));
      i_button = 1'b0;
      tick($urandom_range(1, DB_CYCLES - 1));
    end
    check("bounce_no_pulse", o_state, m_step);
    i_button = 1'b1;
    n = 0;
    while (o_state == 3'(m_step) && n < 20) begin
      tick();
      n++;
    end
    check("bounce_latency", n, PRESS_LAT);
    m_next(v);
    i_button = 1'b0;
    check_all("bounce_press");
    tick(10);
    check_all("bounce_single");

    // Random operator traffic with occasional clears.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) press(0, 1, N_SW'($urandom));
      else                           press(1, 0, N_SW'($urandom));
    end

    // Clear and next landing together in S_OP.
    for (int i = 0; i < 5 && m_step != 2; i++) press(1, 0, N_SW'($urandom));
    check("clr_setup_state", o_state, 32'h2);
    v = {~m_op, 8'($urandom)};
    press(1, 1, v);
    check("clr_state", o_state, 32'h0);
    check("clr_valid", o_result_valid, 32'h0);
    check("clr_op_kept", o_alu_Op, m_op);

    // Reset while the next button is part-way through debounce, button held.
    v = N_SW'($urandom);
    i_sw = v;
    i_button = 1'b1;
    tick(4);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    m_reset();
    check_all("mid_reset");
    tick(PRESS_LAT - 1);
    check("mid_reset_no_early", o_state, 32'h0);
    tick();
    m_next(v);
    check_all("mid_reset_press");
    check("mid_reset_state", o_state, 32'h1);
    i_button = 1'b0;
    tick(10);
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
